// File: rtl/drum_column_sequencer.sv
// Column memory and row sequencer for the drum node datapath: holds curr/prev
// amplitudes for one column and walks rows each sample tick, writing back the time step.
module drum_column_sequencer #(
    parameter int N_ROWS     = 30,
    parameter int ADDR_W     = 5,
    parameter int CENTER_ROW = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              init_we,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [17:0]       init_data,
    output logic [17:0]       node_curr,
    output logic [17:0]       node_prev,
    output logic [17:0]       node_up,
    output logic [17:0]       node_down,
    input  logic [17:0]       node_next,
    output logic [17:0]       row_curr,
    output logic [ADDR_W-1:0] row_idx,
    output logic              row_valid,
    output logic              busy,
    output logic              done,
    output logic [17:0]       center_out
);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_P_RD, S_P_LD, S_RD, S_CALC, S_WR
    } state_t;

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(N_ROWS - 1);
    localparam logic [ADDR_W-1:0] CTR_ROW   = ADDR_W'(CENTER_ROW);
    localparam logic [ADDR_W:0]   ROW_LIMIT = (ADDR_W + 1)'(N_ROWS);

    logic [17:0] curr_mem [DEPTH];
    logic [17:0] prev_mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [17:0]       up_q, up_d, cur_q, cur_d, down_q, down_d, prev_q, prev_d;
    logic [17:0]       next_q, next_d, center_q, center_d;
    logic              done_q, done_d;

    logic              mem_we, curr_re, prev_re;
    logic [ADDR_W-1:0] mem_waddr, curr_raddr, prev_raddr;
    logic [17:0]       curr_wdata, prev_wdata, curr_rd_q, prev_rd_q;
    logic              is_last;
    logic [17:0]       down_sel;

    assign is_last  = (row_q == LAST_ROW);
    assign down_sel = is_last ? '0 : curr_rd_q;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        up_d       = up_q;
        cur_d      = cur_q;
        down_d     = down_q;
        prev_d     = prev_q;
        next_d     = next_q;
        center_d   = center_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = row_q;
        curr_wdata = '0;
        prev_wdata = '0;
        curr_re    = 1'b0;
        curr_raddr = row_q + ADDR_W'(1);
        prev_re    = 1'b0;
        prev_raddr = row_q;
        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (is_last) begin
                    row_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    row_d = row_q + ADDR_W'(1);
                end
            end
            S_IDLE: begin
                // Init write lands before a same-cycle start is acted on.
                if (init_we && ({1'b0, init_addr} < ROW_LIMIT)) begin
                    mem_we     = 1'b1;
                    mem_waddr  = init_addr;
                    curr_wdata = init_data;
                    prev_wdata = init_data;
                end
                if (start) state_d = S_P_RD;
            end
            S_P_RD: begin
                curr_re    = 1'b1;
                curr_raddr = '0;
                state_d    = S_P_LD;
            end
            S_P_LD: begin
                cur_d   = curr_rd_q;
                up_d    = '0;
                row_d   = '0;
                state_d = S_RD;
            end
            S_RD: begin
                curr_re = !is_last;
                prev_re = 1'b1;
                state_d = S_CALC;
            end
            S_CALC: begin
                down_d  = down_sel;
                prev_d  = prev_rd_q;
                next_d  = node_next;
                state_d = S_WR;
            end
            S_WR: begin
                mem_we     = 1'b1;
                curr_wdata = next_q;
                prev_wdata = cur_q;
                up_d       = cur_q;
                cur_d      = down_q;
                if (row_q == CTR_ROW) center_d = next_q;
                if (is_last) begin
                    row_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    row_d   = row_q + ADDR_W'(1);
                    state_d = S_RD;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_CLEAR;
            row_q    <= '0;
            up_q     <= '0;
            cur_q    <= '0;
            down_q   <= '0;
            prev_q   <= '0;
            next_q   <= '0;
            center_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            up_q     <= up_d;
            cur_q    <= cur_d;
            down_q   <= down_d;
            prev_q   <= prev_d;
            next_q   <= next_d;
            center_q <= center_d;
            done_q   <= done_d;
        end
    end

    // Plain RAMs: no reset, synchronous one-cycle read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            curr_mem[mem_waddr] <= curr_wdata;
            prev_mem[mem_waddr] <= prev_wdata;
        end
        if (curr_re) curr_rd_q <= curr_mem[curr_raddr];
        if (prev_re) prev_rd_q <= prev_mem[prev_raddr];
    end

    assign node_curr  = cur_q;
    assign row_curr   = cur_q;
    assign node_up    = up_q;
    assign node_down  = (state_q == S_CALC) ? down_sel : down_q;
    assign node_prev  = (state_q == S_CALC) ? prev_rd_q : prev_q;
    assign row_idx    = row_q;
    assign row_valid  = (state_q == S_CALC);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign center_out = center_q;

endmodule

// File: tb/tb_drum_column_sequencer.sv
// Scoreboard bench for drum_column_sequencer: a column model predicts every row
// presentation and the centre sample; a small node datapath closes the loop.
module tb_drum_column_sequencer;

    localparam int N  = 30;
    localparam int AW = 5;
    localparam int CR = 15;

    logic          clk = 1'b0;
    logic          reset, start, init_we;
    logic [AW-1:0] init_addr;
    logic [17:0]   init_data, node_next;
    logic [17:0]   node_curr, node_prev, node_up, node_down, row_curr, center_out;
    logic [AW-1:0] row_idx;
    logic          row_valid, busy, done;

    drum_column_sequencer #(.N_ROWS(N), .ADDR_W(AW), .CENTER_ROW(CR)) dut (
        .clk(clk), .reset(reset), .start(start), .init_we(init_we),
        .init_addr(init_addr), .init_data(init_data),
        .node_curr(node_curr), .node_prev(node_prev), .node_up(node_up),
        .node_down(node_down), .node_next(node_next), .row_curr(row_curr),
        .row_idx(row_idx), .row_valid(row_valid), .busy(busy), .done(done),
        .center_out(center_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] row;
        logic [17:0]   c, p, u, d;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [17:0] cm[N];
    logic [17:0] pm[N];
    logic [17:0] center_m;
    int          n_cmp = 0, n_bad = 0, done_cnt = 0, rv_cnt = 0, mode = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: echo curr, mode 1: row index, mode 2: leapfrog wave node, rho = 1/8
    function automatic logic [17:0] node_fn(input int m, input logic [AW-1:0] r,
                                            input logic [17:0] c, input logic [17:0] p,
                                            input logic [17:0] u, input logic [17:0] d);
        logic signed [19:0] cs, ps, us, ds, lap, acc;
        cs  = {{2{c[17]}}, c};
        ps  = {{2{p[17]}}, p};
        us  = {{2{u[17]}}, u};
        ds  = {{2{d[17]}}, d};
        lap = us + ds - (cs <<< 2);
        acc = (cs <<< 1) - ps + (lap >>> 3);
        case (m)
            0:       return c;
            1:       return 18'(r);
            default: return acc[17:0];
        endcase
    endfunction

    always_comb node_next = node_fn(mode, row_idx, node_curr, node_prev, node_up, node_down);

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (row_valid === 1'b1) begin
            rv_cnt++;
            if (sb.size() == 0) begin
                chk("sb_unexpected_row", 32'(row_idx), 32'(N));
            end else begin
                mon_e = sb.pop_front();
                chk("row_idx",   32'(row_idx),   32'(mon_e.row));
                chk("node_curr", 32'(node_curr), 32'(mon_e.c));
                chk("row_curr",  32'(row_curr),  32'(mon_e.c));
                chk("node_prev", 32'(node_prev), 32'(mon_e.p));
                chk("node_up",   32'(node_up),   32'(mon_e.u));
                chk("node_down", 32'(node_down), 32'(mon_e.d));
            end
        end
    end

    task automatic apply_init(input logic [AW-1:0] a, input logic [17:0] v);
        if (int'(a) < N) begin
            cm[a] = v;
            pm[a] = v;
        end
    endtask

    task automatic init_row(input logic [AW-1:0] a, input logic [17:0] v);
        @(negedge clk);
        init_we = 1'b1; init_addr = a; init_data = v;
        @(negedge clk);
        init_we = 1'b0;
        apply_init(a, v);
    endtask

    task automatic push_step(input int m);
        logic [17:0] nx[N];
        exp_t        el;
        for (int r = 0; r < N; r++) begin
            el.row = AW'(r);
            el.c   = cm[r];
            el.p   = pm[r];
            el.u   = (r == 0)     ? 18'h0 : cm[r-1];
            el.d   = (r == N - 1) ? 18'h0 : cm[r+1];
            sb.push_back(el);
            nx[r] = node_fn(m, el.row, el.c, el.p, el.u, el.d);
        end
        center_m = nx[CR];
        for (int r = 0; r < N; r++) begin
            pm[r] = cm[r];
            cm[r] = nx[r];
        end
    endtask

    task automatic zero_model();
        for (int r = 0; r < N; r++) begin
            cm[r] = '0;
            pm[r] = '0;
        end
        center_m = '0;
    endtask

    task automatic run_step(input int m, input bit pulse_busy, input bit co_init,
                            input logic [AW-1:0] ia, input logic [17:0] iv);
        int cnt, d0, rv0;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        if (co_init) begin
            init_we = 1'b1; init_addr = ia; init_data = iv;
            apply_init(ia, iv);
        end
        push_step(m);
        d0  = done_cnt;
        rv0 = rv_cnt;
        @(posedge clk); #1;
        start = 1'b0; init_we = 1'b0;
        cnt = 1;
        while (done !== 1'b1 && cnt < 200) begin
            if (pulse_busy && cnt == 40) begin
                start = 1'b1; init_we = 1'b1; init_addr = 5; init_data = 18'h2AAAA;
            end else begin
                start = 1'b0; init_we = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0; init_we = 1'b0;
        chk("done_latency", 32'(cnt - 1), 32'(3 * N + 2));
        chk("busy_at_done", 32'(busy), 32'(0));
        chk("center_out", 32'(center_out), 32'(center_m));
        @(posedge clk); #1;
        chk("done_width", 32'(done), 32'(0));
        @(negedge clk); #1;
        chk("done_count", 32'(done_cnt - d0), 32'(1));
        chk("row_valid_count", 32'(rv_cnt - rv0), 32'(N));
        chk("sb_drained", 32'(sb.size()), 32'(0));
    endtask

    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(tag, 32'(cnt), 32'(N));
    endtask

    task automatic abort_at_row10();
        int cnt, d0;
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        push_step(0);
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (!(row_valid === 1'b1 && row_idx == 10) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("abort_row", 32'(row_idx), 32'(10));
        reset = 1'b0;
        sb.delete();
        zero_model();
        #1;
        chk("abort_busy", 32'(busy), 32'(1));
        chk("abort_row_valid", 32'(row_valid), 32'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_clear("clear_cycles_after_abort");
        @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'(0));
        chk("abort_center", 32'(center_out), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
        zero_model();
        #1;
        chk("rst_busy",      32'(busy),       32'(1));
        chk("rst_row_valid", 32'(row_valid),  32'(0));
        chk("rst_done",      32'(done),       32'(0));
        chk("rst_center",    32'(center_out), 32'(0));
        chk("rst_row_idx",   32'(row_idx),    32'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_clear("clear_cycles");

        run_step(0, 1'b0, 1'b0, '0, '0);

        init_row(15, 18'h04000);
        run_step(0, 1'b0, 1'b0, '0, '0);

        init_row(0, 18'h10000);
        init_row(29, 18'h10000);
        run_step(0, 1'b0, 1'b0, '0, '0);

        run_step(1, 1'b0, 1'b0, '0, '0);
        run_step(1, 1'b0, 1'b0, '0, '0);

        run_step(0, 1'b1, 1'b0, '0, '0);
        run_step(0, 1'b0, 1'b1, 3, 18'h3F000);

        abort_at_row10();
        run_step(0, 1'b0, 1'b0, '0, '0);

        init_row(15, 18'h04000);
        for (int s = 0; s < 8; s++) run_step(2, 1'b0, 1'b0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/drum_column_sequencer.md
Name: drum_column_sequencer

Overview:
- Memory and sequencing stage that sits directly upstream of the single-node drum update datapath.
- Holds one column of N_ROWS drum nodes (current and previous amplitude) in two inferred simple-dual-port RAMs.
- Each sample tick, walks rows 0..N_ROWS-1, presents curr/prev/up/down amplitudes to the node datapath, captures the node's next value and writes the time step back.
- Exports the row amplitude for neighbouring columns' left/right inputs, plus a registered centre-node sample for audio.

Parameters:
N_ROWS, 30, rows in the column (>=3)
ADDR_W, 5, RAM address width, 2**ADDR_W >= N_ROWS
CENTER_ROW, 15, row whose new value drives center_out

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: compute one time step; honoured only in IDLE
init_we  in  1  initial-condition write strobe; honoured only in IDLE
init_addr  in  ADDR_W  row for init write
init_data  in  18  signed 1.17 value written to both curr and prev RAM at init_addr
node_curr  out  18  signed 1.17 curr_u of active row
node_prev  out  18  signed 1.17 prev_u of active row
node_up  out  18  curr of row i-1; 0 when i==0
node_down  out  18  curr of row i+1; 0 when i==N_ROWS-1
node_next  in  18  signed 1.17 result from node datapath, sampled in CALC
row_curr  out  18  same as node_curr, routed to neighbouring columns
row_idx  out  ADDR_W  active row index
row_valid  out  1  high in CALC: node_* and row_curr valid this cycle
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when a time step completes
center_out  out  18  registered node_next of CENTER_ROW from the last completed step

Behaviour:
- Reset (reset low, async): state=CLEAR, row counter=0, up_reg/cur_reg/down_reg/prev_reg=0, center_out=0, done=0, busy=1, row_valid=0.
- CLEAR: one row per cycle, writes 0 to curr[row] and prev[row] for rows 0..N_ROWS-1 (N_ROWS cycles), then IDLE. RAM contents are not otherwise reset.
- IDLE: busy=0.
  - init_we writes init_data to both RAMs at init_addr the same cycle; init_addr >= N_ROWS is ignored.
  - start moves to P_RD; if start and init_we are both high, the write happens first and start is still accepted.
- P_RD: read address curr[0]. Next state is P_LD.
- P_LD: cur_reg <= curr rd data; up_reg <= 0; i=0.
- Per row i, three states:
  - RD: issue reads curr[i+1] (skipped for the last row) and prev[i].
  - CALC:
    - down_reg <= curr rd data, or 0 if i==N_ROWS-1; prev_reg <= prev rd data.
    - Outputs driven from these values combinationally (down/prev take the RAM data in this cycle).
    - row_valid=1.
    - node_next sampled at the end of CALC into next_reg.
  - WR:
    - curr[i] <= next_reg; prev[i] <= cur_reg.
    - up_reg <= cur_reg; cur_reg <= down_reg.
    - If i==CENTER_ROW, center_out <= next_reg.
    - If i==N_ROWS-1, go to IDLE with done=1 on the next cycle; else i++ and go to RD.
- Latency: start sampled at edge k, done high in cycle k+3*N_ROWS+2.
- Read-during-write: old data is never needed; row i is written only after rows i-1..i+1 are already captured in registers.
- start and init_we outside IDLE are ignored, not queued.
- Reset asserted mid-step aborts the step: no done pulse, restarts CLEAR.
- Arithmetic: pure data movement, no arithmetic; all values 18-bit signed 1.17, no truncation or saturation.

Test Plan:
- Reset then release -> busy=1 for exactly N_ROWS cycles (CLEAR), then busy=0; a subsequent step with node_next=node_curr echo leaves all rows 0 and center_out=0.
- Init row 15 with 18'h04000 (0.125), start, bench echoes node_curr -> row_valid seen 30 times; row 14 node_down=18'h04000, row 16 node_up=18'h04000, row 15 node_prev=18'h04000; done at start+92 cycles.
- Boundary check: init rows 0 and 29 with 18'h10000 -> row 0 node_up=0, row 29 node_down=0, row 1 node_up=18'h10000.
- Bench returns node_next = row_idx (zero-extended) -> after step, center_out=15; second step shows node_prev=old curr and node_curr=row_idx per row.
- Start and init_we pulsed while busy -> no RAM change, no extra done, done count = 1.
- Reset low at CALC of row 10 -> done never pulses, busy stays 1 through CLEAR, all rows read back 0 on next step.
- Full loop with the real node datapath (rho_eff=0.125, row 15 at 0.125) -> center_out matches the bench's golden model bit-exactly for 8 consecutive steps.
